// File: rtl/nd_array_reduce.sv
// nd_array_reduce: D0 x D1 x D2 register array of W-bit elements with a random-access
// write/read port and a sequential reduction engine.
//
// A start pulse in IDLE sweeps every element in row-major order (k fastest), LANES elements
// per cycle, and produces an ACC_W-bit reduction. The array is owned by the engine while
// busy, so host writes are dropped during a sweep.
//
// Modes: 00 unsigned sum, 01 sign-extended sum, 10 increment-and-sum with write-back,
//        11 clear (write 0, result 0).
//
// Optional build macro REDUCE_MAX_EN adds max_out: the largest element seen by the last
// sweep (signed compare in mode 01, unsigned otherwise, post-write values in modes 10/11).
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   wr_en, wr_i/j/k, wr_data   host write, honoured only in IDLE and for in-range indices
//   rd_i/j/k, rd_data          combinational read, 0 for out-of-range indices
//   start, mode                begin a reduction (sampled only in IDLE), operation select
//   busy                       high from the first sweep cycle through the done cycle
//   done                       one-cycle pulse when result/ovf are valid
//   result, ovf                last reduction result and overflow flag, held until next done
//   max_out                    (REDUCE_MAX_EN only) maximum element of the last sweep
module nd_array_reduce #(
  parameter int unsigned D0    = 2,
  parameter int unsigned D1    = 3,
  parameter int unsigned D2    = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned LANES = 1,
  localparam int unsigned IW   = (D0 > 1) ? $clog2(D0) : 1,
  localparam int unsigned JW   = (D1 > 1) ? $clog2(D1) : 1,
  localparam int unsigned KW   = (D2 > 1) ? $clog2(D2) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_i,
  input  logic [JW-1:0]    wr_j,
  input  logic [KW-1:0]    wr_k,
  input  logic [W-1:0]     wr_data,
  input  logic [IW-1:0]    rd_i,
  input  logic [JW-1:0]    rd_j,
  input  logic [KW-1:0]    rd_k,
  output logic [W-1:0]     rd_data,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
`ifdef REDUCE_MAX_EN
  output logic [W-1:0]     max_out,
`endif
  output logic             ovf
);

  localparam int unsigned N  = D0 * D1 * D2;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0] ILast = IW'(D0 - 1);
  localparam logic [JW-1:0] JLast = JW'(D1 - 1);
  localparam logic [KW-1:0] KLast = KW'(D2 - LANES);
  localparam logic [KW-1:0] KStep = KW'(LANES);

  typedef enum logic [1:0] {StIdle, StSweep, StFin} state_e;

  state_e state_q, state_d;

  logic [W-1:0]     mem_q [N];
  logic [1:0]       mode_q;
  logic [IW-1:0]    i_q;
  logic [JW-1:0]    j_q;
  logic [KW-1:0]    k_q;
  logic [ACC_W-1:0] acc_q;
  logic             trk_q;
  logic [ACC_W-1:0] result_q;
  logic             ovf_q;

  // Row-major flat address of element [i][j][k].
  function automatic logic [AW-1:0] flat_addr(input logic [IW-1:0] i, input logic [JW-1:0] j,
                                              input logic [KW-1:0] k);
    logic [31:0] a;
    a = (32'(i) * D1 + 32'(j)) * D2 + 32'(k);
    return AW'(a);
  endfunction

  function automatic logic in_range(input logic [IW-1:0] i, input logic [JW-1:0] j,
                                    input logic [KW-1:0] k);
    return (32'(i) < D0) && (32'(j) < D1) && (32'(k) < D2);
  endfunction

  // ---------------------------------------------------------------------------
  // Host port
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_ok, rd_ok;

  assign wr_addr = flat_addr(wr_i, wr_j, wr_k);
  assign rd_addr = flat_addr(rd_i, rd_j, rd_k);
  assign wr_ok   = wr_en && (state_q == StIdle) && in_range(wr_i, wr_j, wr_k);
  assign rd_ok   = in_range(rd_i, rd_j, rd_k);
  assign rd_data = rd_ok ? mem_q[rd_addr] : '0;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic last_group;

  assign last_group = (i_q == ILast) && (j_q == JLast) && (k_q == KLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSweep;
      StSweep: if (last_group) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StFin);

  // ---------------------------------------------------------------------------
  // Group datapath: LANES elements folded into the accumulator per cycle. Lanes are
  // chained so overflow is tracked on every per-element partial sum.
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    base_addr;
  logic [AW-1:0]    lane_addr [LANES];
  logic [W-1:0]     val       [LANES];
  logic [ACC_W-1:0] addend    [LANES];
  logic [ACC_W:0]   psum      [LANES];
  logic [ACC_W-1:0] acc_nxt;
  logic             trk_nxt;

  assign base_addr = flat_addr(i_q, j_q, k_q);

  always_comb begin
    acc_nxt = acc_q;
    trk_nxt = trk_q;
    for (int l = 0; l < LANES; l++) begin
      lane_addr[l] = AW'(32'(base_addr) + 32'(l));
      val[l]       = mem_q[lane_addr[l]];
      addend[l]    = '0;
      unique case (mode_q)
        2'b00: addend[l] = ACC_W'(val[l]);
        2'b01: addend[l] = ACC_W'($signed(val[l]));
        2'b10: begin
          val[l]    = val[l] + 1'b1;
          addend[l] = ACC_W'(val[l]);
        end
        2'b11: val[l] = '0;
      endcase
      psum[l] = {1'b0, acc_nxt} + {1'b0, addend[l]};
      if (mode_q == 2'b01) begin
        // Signed overflow: like-signed operands producing a sum of the other sign.
        trk_nxt |= (acc_nxt[ACC_W-1] == addend[l][ACC_W-1]) &&
                   (psum[l][ACC_W-1] != acc_nxt[ACC_W-1]);
      end else begin
        trk_nxt |= psum[l][ACC_W];
      end
      acc_nxt = psum[l][ACC_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Engine registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 2'b00;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      trk_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      mode_q <= mode;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      trk_q  <= 1'b0;
    end else if (state_q == StSweep) begin
      acc_q <= acc_nxt;
      trk_q <= trk_nxt;
      if (last_group) begin
        // Publish at the edge into FIN so result is valid alongside done.
        result_q <= acc_nxt;
        ovf_q    <= trk_nxt;
        i_q      <= '0;
        j_q      <= '0;
        k_q      <= '0;
      end else if (k_q == KLast) begin
        k_q <= '0;
        if (j_q == JLast) begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end else begin
        k_q <= k_q + KStep;
      end
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;

  // ---------------------------------------------------------------------------
  // Array storage: host writes in IDLE, engine write-back during SWEEP (modes 10/11).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) begin
        mem_q[n] <= '0;
      end
    end else if (state_q == StIdle) begin
      if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
    end else if ((state_q == StSweep) && mode_q[1]) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[lane_addr[l]] <= val[l];
      end
    end
  end

`ifdef REDUCE_MAX_EN
  // ---------------------------------------------------------------------------
  // Running maximum of post-write element values.
  // ---------------------------------------------------------------------------
  logic [W-1:0] max_run_q, max_nxt, max_q;

  always_comb begin
    max_nxt = max_run_q;
    for (int l = 0; l < LANES; l++) begin
      if (mode_q == 2'b01) begin
        if ($signed(val[l]) > $signed(max_nxt)) max_nxt = val[l];
      end else if (val[l] > max_nxt) begin
        max_nxt = val[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_run_q <= '0;
      max_q     <= '0;
    end else if ((state_q == StIdle) && start) begin
      // Signed sweeps start from the most negative value so all-negative arrays work.
      max_run_q <= (mode == 2'b01) ? {1'b1, {(W-1){1'b0}}} : '0;
    end else if (state_q == StSweep) begin
      max_run_q <= max_nxt;
      if (last_group) max_q <= max_nxt;
    end
  end

  assign max_out = max_q;
`endif

endmodule

// File: doc/nd_array_reduce.md
Name: nd_array_reduce

Overview:
- Parametrised 3-D register array (D0 x D1 x D2 elements of W bits) with a random-access write/read port and a sequential reduction engine.
- On start, the engine sweeps every element in row-major order, LANES elements per cycle, and produces an ACC_W-bit reduction.
- Modes: unsigned sum, sign-extended sum, increment-and-sum with write-back, and clear.
- Successor to the combinational foreach-sum blocks. Used as a scratch-array accumulator beside datapath state.

Parameters:
- D0, 2, outer dimension size (>=1)
- D1, 3, middle dimension size (>=1)
- D2, 4, inner dimension size (>=1); k is the fastest-varying index
- W, 16, element width (>=2)
- ACC_W, 32, accumulator/result width (>=W)
- LANES, 1, elements processed per sweep cycle; must divide D2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_i  in  max(1,clog2(D0))  write outer index
- wr_j  in  max(1,clog2(D1))  write middle index
- wr_k  in  max(1,clog2(D2))  write inner index
- wr_data  in  W  write data
- rd_i/rd_j/rd_k  in  same widths as wr_*  read indices
- rd_data  out  W  combinational read of element [rd_i][rd_j][rd_k]
- start  in  1  begin reduction; sampled only in IDLE
- mode  in  2  00 unsigned sum, 01 signed sum, 10 increment-and-sum, 11 clear
- busy  out  1  high while a reduction is in progress
- done  out  1  one-cycle pulse when result is valid
- result  out  ACC_W  last reduction result, held until the next done
- ovf  out  1  overflow flag of the last reduction, updated with done

Behaviour:
- Reset (async, rst_n=0):
  - all array elements 0
  - FSM to IDLE
  - busy=0, done=0, result=0, ovf=0, internal accumulator and indices 0
  - Reset mid-sweep aborts the sweep; no done is produced.
- FSM states: IDLE, SWEEP, FIN.
- IDLE:
  - start=1 latches mode, clears the accumulator and overflow tracker, sets (i,j,k)=(0,0,0), and moves to SWEEP.
- SWEEP, one group per cycle:
  - Processes elements [i][j][k .. k+LANES-1].
  - Index advance: k += LANES; k wraps to 0 and increments j; j wraps to 0 and increments i.
  - The final group (i=D0-1, j=D1-1, k=D2-LANES) moves to FIN.
- FIN:
  - result <= accumulator; ovf <= tracker; done=1 for this cycle only.
  - Returns to IDLE.
- Latency: start sampled in cycle 0. SWEEP occupies cycles 1..G, where G = D0*D1*D2/LANES. done and result are valid in cycle G+1. busy=1 for cycles 1..G+1 inclusive.
- Mode arithmetic, per element e:
  - 00: accumulator += zero-extend(e) to ACC_W.
  - 01: accumulator += sign-extend(e) from bit W-1 to ACC_W.
  - 10: e' = (e+1) mod 2^W is written back in the same cycle; accumulator += zero-extend(e').
  - 11: element is written to 0 and adds nothing; result=0, ovf=0.
  - All LANES elements of a group are summed in one cycle.
- Overflow:
  - Unsigned modes: ovf=1 if the true sum >= 2^ACC_W.
  - Signed mode: ovf=1 if any partial sum leaves the signed ACC_W range.
  - The result wraps mod 2^ACC_W.
- Writes:
  - wr_en in IDLE writes wr_data on the rising edge.
  - wr_en while busy=1 is dropped; the array is owned by the engine.
  - Out-of-range indices (>= Dn) are ignored.
- start while busy is ignored. start and wr_en together in IDLE: the write lands first, and the sweep sees the new value.
- rd_data reflects the current register contents, including mid-sweep write-back. Out-of-range read returns 0.

Optional Feature:
- Macro: REDUCE_MAX_EN.
- Defined:
  - Adds output max_out (W bits), updated with done.
  - Holds the maximum element seen in the sweep: signed compare in mode 01, unsigned otherwise.
  - Mode 10 uses post-increment values; mode 11 yields 0.
  - Reset value 0.
- Undefined: port max_out is absent and no comparator logic is present.

Test Plan:
- Defaults, reset, start mode 00 -> busy 1 in cycles 1..25, done pulse in cycle 25 only, result=0, ovf=0.
- Write [0][2][3]=1 and [1][2][3]=1, mode 00 -> result=2. Write during busy -> dropped, rd_data unchanged afterwards.
- Write [0][0][0]=16'h8000, mode 01 -> result=32'hFFFF8000. Repeat with mode 00 -> result=32'h00008000.
- Write [0][0][0..3]=1,2,3,4 (others 0), mode 10 -> result=34; rd [0][0][0]=2, rd [1][2][3]=1. Element 16'hFFFF -> reads 0 after the sweep.
- ACC_W=17, all 24 elements 16'hFFFF, mode 00 -> result=131048, ovf=1. Mode 11 afterwards -> result=0, ovf=0, all rd_data=0.
- LANES=2: sweep done in cycle 13. Assert rst_n=0 in cycle 5 of a mode-10 sweep -> busy=0, no done, array all 0. Run with REDUCE_MAX_EN, [1][1][1]=16'h7FFF, mode 01 -> max_out=16'h7FFF.
